fetch_queue: RTL and testbench

Small circular buffer placed directly downstream of the fetch stage, between IF and ID. Captures each fetched {PC+4, instruction} pair and presents the oldest one to the decode stage. Decouples fetch from decode stalls: IF keeps fetching while ID is frozen until the queue fills, then `fullOut` freezes IF. A taken branch discards all queued wrong-path instructions in one cycle.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_ram.sv | 30 +++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue.
//   FQ_N              default width of PC and instruction
//   FQ_DEPTH_DEFAULT  default number of queue entries
//   BUBBLE            instruction shown to decode when the queue is empty
//   fq_entry_t        one queued fetch: {pc, instr}
package fetch_queue_pkg;

   localparam int FQ_N             = 32;
   localparam int FQ_DEPTH_DEFAULT = 4;

   localparam logic [FQ_N-1:0] BUBBLE = 32'h0000_0000;

   typedef struct packed {
      logic [FQ_N-1:0] pc;
      logic [FQ_N-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for the fetch queue.
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (asynchronous read)
//   rdata_o  read data
// Data is not reset; the top-level occupancy count decides what is valid.
module fetch_queue_ram #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Circular buffer between fetch (IF) and decode (ID).
// Captures {PC+4, instruction} pairs from IF and presents the oldest to ID.
//   clk, rst        clock, asynchronous active-high reset
//   wrEnIn          IF presents a valid fetch
//   PCIn            PC+4 from IF
//   instructionIn   instruction from IF
//   flushIn         taken branch: drop all entries and this cycle's fetch
//   freezeIn        ID stall: hold the head entry
//   fullOut         queue full (freezes IF)
//   validOut        head entry valid
//   PCOut           head PC+4 (0 when empty)
//   instructionOut  head instruction (BUBBLE when empty)
//   countOut        occupancy
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty and
// decode is not frozen, an incoming fetch is forwarded to the outputs in the
// same cycle and consumed without being stored.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int N     = FQ_N,
   parameter int DEPTH = FQ_DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wrEnIn,
   input  logic [N-1:0]  PCIn,
   input  logic [N-1:0]  instructionIn,
   input  logic          flushIn,
   input  logic          freezeIn,
   output logic          fullOut,
   output logic          validOut,
   output logic [N-1:0]  PCOut,
   output logic [N-1:0]  instructionOut,
   output logic [CW-1:0] countOut
);

   logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] rd_data;
   logic           empty, full, pop, push, bypass;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign pop   = ~empty & ~freezeIn;

`ifdef FETCH_QUEUE_BYPASS_EN
   // rst term keeps the outputs at the reset value while reset is held.
   assign bypass = empty & wrEnIn & ~freezeIn & ~flushIn & ~rst;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed fetch is consumed on the spot, so it is never written.
   assign push = wrEnIn & (~full | pop) & ~bypass;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flushIn) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wp_d = wp_q + 1'b1;
         if (pop)  rp_d = rp_q + 1'b1;
         if (push & ~pop)      cnt_d = cnt_q + 1'b1;
         else if (pop & ~push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   fetch_queue_ram #(
      .W     (2 * N),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (push & ~flushIn),
      .waddr_i (wp_q),
      .wdata_i ({PCIn, instructionIn}),
      .raddr_i (rp_q),
      .rdata_o (rd_data)
   );

   always_comb begin
      if (bypass) begin
         PCOut          = PCIn;
         instructionOut = instructionIn;
      end else if (empty) begin
         PCOut          = '0;
         instructionOut = N'(BUBBLE);
      end else begin
         PCOut          = rd_data[2*N-1:N];
         instructionOut = rd_data[N-1:0];
      end
   end

   assign validOut = ~empty | bypass;
   assign fullOut  = full;
   assign countOut = cnt_q;

   // IF is expected to be frozen by fullOut before it would lose a fetch.
   a_no_drop: assert property (@(posedge clk) disable iff (rst)
      !(wrEnIn && full && !pop && !flushIn))
      else $warning("fetch_queue: fetch dropped while full");

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int N     = 32;
   localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wrEnIn, flushIn, freezeIn;
   logic [N-1:0]  PCIn, instructionIn;
   logic          fullOut, validOut;
   logic [N-1:0]  PCOut, instructionOut;
   logic [2:0]    countOut;

   int checks = 0;
   int errors = 0;

   // bench-side copy of the driven inputs
   logic          d_wr, d_fl, d_fr;
   logic [N-1:0]  d_pc;

   fq_entry_t model_q[$];

   fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .wrEnIn         (wrEnIn),
      .PCIn           (PCIn),
      .instructionIn  (instructionIn),
      .flushIn        (flushIn),
      .freezeIn       (freezeIn),
      .fullOut        (fullOut),
      .validOut       (validOut),
      .PCOut          (PCOut),
      .instructionOut (instructionOut),
      .countOut       (countOut)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] ins_of(input logic [N-1:0] pc);
      return pc * 3 + 32'h1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input logic [N-1:0] pc, input logic fl, input logic fr);
      d_wr = wr; d_pc = pc; d_fl = fl; d_fr = fr;
      wrEnIn        = wr;
      PCIn          = pc;
      instructionIn = ins_of(pc);
      flushIn       = fl;
      freezeIn      = fr;
   endtask

   task automatic model_check(input string tag);
      int            sz;
      bit            byp;
      logic [N-1:0]  e_pc, e_ins;
      sz  = model_q.size();
      byp = BYP && sz == 0 && d_wr && !d_fr && !d_fl;
      if (byp) begin
         e_pc = d_pc; e_ins = ins_of(d_pc);
      end else if (sz != 0) begin
         e_pc = model_q[0].pc; e_ins = model_q[0].instr;
      end else begin
         e_pc = '0; e_ins = BUBBLE;
      end
      chk({tag, ".pc"},    PCOut, e_pc);
      chk({tag, ".instr"}, instructionOut, e_ins);
      chk({tag, ".valid"}, 32'(validOut), 32'(byp || sz != 0));
      chk({tag, ".full"},  32'(fullOut), 32'(sz == DEPTH));
      chk({tag, ".count"}, 32'(countOut), 32'(sz));
   endtask

   // queue semantics of one clock edge
   task automatic model_step();
      int        sz;
      bit        byp, popv, full;
      fq_entry_t e;
      sz = model_q.size();
      if (d_fl) begin
         model_q.delete();
      end else begin
         byp  = BYP && sz == 0 && d_wr && !d_fr;
         popv = sz != 0 && !d_fr;
         full = sz == DEPTH;
         if (!byp) begin
            if (popv) void'(model_q.pop_front());
            if (d_wr && (!full || popv)) begin
               e.pc = d_pc; e.instr = ins_of(d_pc);
               model_q.push_back(e);
            end
         end
      end
   endtask

   task automatic model_cycle(input string tag, input logic wr, input logic [N-1:0] pc,
                              input logic fl, input logic fr);
      drive(wr, pc, fl, fr);
      #1;
      model_check(tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      model_q.delete();
      chk("rst.valid", 32'(validOut), 32'd0);
      chk("rst.full",  32'(fullOut), 32'd0);
      chk("rst.count", 32'(countOut), 32'd0);
      chk("rst.pc",    PCOut, 32'd0);
      chk("rst.instr", instructionOut, BUBBLE);
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifndef FETCH_QUEUE_BYPASS_EN
   typedef struct {
      logic        wr;
      logic [31:0] pc;
      logic        fl;
      logic        fr;
      logic [31:0] e_pc;
      logic        e_v;
      int          e_cnt;
      logic        e_full;
   } vec_t;

   vec_t tbl[26];

   function automatic vec_t mk(input logic wr, input logic [31:0] pc, input logic fl,
                               input logic fr, input logic [31:0] e_pc, input logic e_v,
                               input int e_cnt, input logic e_full);
      vec_t v;
      v.wr = wr; v.pc = pc; v.fl = fl; v.fr = fr;
      v.e_pc = e_pc; v.e_v = e_v; v.e_cnt = e_cnt; v.e_full = e_full;
      return v;
   endfunction

   task automatic run_table();
      // expected values are the outputs before the edge of that row
      tbl[0]  = mk(1, 4,  0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(1, 8,  0, 0,  4, 1, 1, 0);
      tbl[2]  = mk(1, 12, 0, 0,  8, 1, 1, 0);
      tbl[3]  = mk(1, 16, 0, 0, 12, 1, 1, 0);
      tbl[4]  = mk(0, 0,  0, 0, 16, 1, 1, 0);
      tbl[5]  = mk(0, 0,  0, 0,  0, 0, 0, 0);
      tbl[6]  = mk(1, 4,  0, 1,  0, 0, 0, 0);
      tbl[7]  = mk(1, 8,  0, 1,  4, 1, 1, 0);
      tbl[8]  = mk(1, 12, 0, 1,  4, 1, 2, 0);
      tbl[9]  = mk(1, 16, 0, 1,  4, 1, 3, 0);
      tbl[10] = mk(1, 99, 0, 1,  4, 1, 4, 1);
      tbl[11] = mk(0, 0,  0, 1,  4, 1, 4, 1);
      tbl[12] = mk(1, 20, 0, 0,  4, 1, 4, 1);
      tbl[13] = mk(0, 0,  0, 0,  8, 1, 4, 1);
      tbl[14] = mk(0, 0,  0, 0, 12, 1, 3, 0);
      tbl[15] = mk(0, 0,  0, 0, 16, 1, 2, 0);
      tbl[16] = mk(0, 0,  0, 0, 20, 1, 1, 0);
      tbl[17] = mk(0, 0,  0, 0,  0, 0, 0, 0);
      tbl[18] = mk(1, 24, 0, 1,  0, 0, 0, 0);
      tbl[19] = mk(1, 28, 0, 1, 24, 1, 1, 0);
      tbl[20] = mk(1, 32, 0, 1, 24, 1, 2, 0);
      tbl[21] = mk(1, 36, 1, 0, 24, 1, 3, 0);
      tbl[22] = mk(0, 0,  0, 0,  0, 0, 0, 0);
      tbl[23] = mk(1, 44, 0, 0,  0, 0, 0, 0);
      tbl[24] = mk(0, 0,  0, 0, 44, 1, 1, 0);
      tbl[25] = mk(0, 0,  0, 0,  0, 0, 0, 0);
      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].wr, tbl[i].pc, tbl[i].fl, tbl[i].fr);
         #1;
         chk($sformatf("tbl%0d.pc", i),    PCOut, tbl[i].e_pc);
         chk($sformatf("tbl%0d.instr", i), instructionOut,
             tbl[i].e_v ? ins_of(tbl[i].e_pc) : BUBBLE);
         chk($sformatf("tbl%0d.valid", i), 32'(validOut), 32'(tbl[i].e_v));
         chk($sformatf("tbl%0d.count", i), 32'(countOut), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.full", i),  32'(fullOut), 32'(tbl[i].e_full));
         @(posedge clk);
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      do_reset();

`ifndef FETCH_QUEUE_BYPASS_EN
      run_table();
`else
      // same-cycle forwarding into an empty queue
      drive(1'b1, 32'd40, 1'b0, 1'b0);
      #1;
      chk("byp.pc",    PCOut, 32'd40);
      chk("byp.instr", instructionOut, ins_of(32'd40));
      chk("byp.valid", 32'(validOut), 32'd1);
      chk("byp.count", 32'(countOut), 32'd0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("byp.after_count", 32'(countOut), 32'd0);
      chk("byp.after_valid", 32'(validOut), 32'd0);
      @(negedge clk);
`endif

      do_reset();
      // streaming through the pointers with decode never stalled
      for (int i = 0; i < 10; i++)
         model_cycle("wrap", 1'b1, 32'(100 + 4 * i), 1'b0, 1'b0);
      model_cycle("wrap_drain", 1'b0, '0, 1'b0, 1'b0);

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         logic wr, fl, fr;
         wr = ($urandom_range(0, 99) < 70);
         fr = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 5);
         // keep IF well-behaved: no fetch offered while the queue would drop it
         if (model_q.size() == DEPTH && fr && !fl) wr = 1'b0;
         model_cycle("rnd", wr, $urandom, fl, fr);
      end

      // asynchronous reset in the middle of traffic
      model_cycle("mid", 1'b1, 32'h200, 1'b0, 1'b1);
      model_cycle("mid", 1'b1, 32'h204, 1'b0, 1'b1);
      model_cycle("mid", 1'b0, '0, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.valid", 32'(validOut), 32'd0);
      chk("async_rst.count", 32'(countOut), 32'd0);
      chk("async_rst.pc",    PCOut, 32'd0);
      chk("async_rst.instr", instructionOut, BUBBLE);
      model_q.delete();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      model_cycle("post_rst", 1'b1, 32'h300, 1'b0, 1'b0);
      model_cycle("post_rst", 1'b0, '0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
